bp_be_rollback_queue: RTL and testbench
=======================================

Name: bp_be_rollback_queue

Overview:
- Parametrised, replayable instruction buffer between the FE queue and the BE issue/dispatch logic.
- Keeps every fetched entry until the commit stage retires it, so that:
  - a rollback replays all issued-but-uncommitted entries;
  - a clear discards all uncommitted entries.
- Generalises the single-commit FE issue buffer with configurable depth and entry width, multi-entry commit per cycle, and exported occupancy counters for the checker.

Parameters:
- els_p, 16: queue depth; power of 2, at least 2.
- width_p, 128: entry width in bits (FE queue packet).
- deq_width_p, 2: maximum entries committed per cycle; 1 to els_p.
- Derived: ptr_width_lp = $clog2(els_p)+1 (index plus wrap bit); cnt_width_lp = $clog2(els_p+1); deq_cnt_width_lp = $clog2(deq_width_p+1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- data_i  in  width_p  entry to enqueue.
- v_i  in  1  enqueue valid.
- ready_o  out  1  queue can accept an entry.
- data_o  out  width_p  entry at the issue pointer.
- v_o  out  1  data_o valid (unissued entry present).
- yumi_i  in  1  consumer takes data_o; legal only when v_o.
- deq_cnt_i  in  deq_cnt_width_lp  number of entries committed this cycle.
- roll_v_i  in  1  rewind the issue pointer to the commit point.
- clr_v_i  in  1  discard all uncommitted entries.
- empty_o  out  1  no entries held (committed == written).
- free_cnt_o  out  cnt_width_lp  free slots.
- pending_cnt_o  out  cnt_width_lp  written but not issued.
- inflight_cnt_o  out  cnt_width_lp  issued but not committed.

Behaviour:
- State:
  - pointers wptr, rptr, cptr, each ptr_width_lp bits, wrapping modulo 2*els_p;
  - storage els_p x width_p, indexed by the low $clog2(els_p) bits of each pointer.
- Invariant: cptr <= rptr <= wptr in modular distance; wptr - cptr <= els_p.
- Reset: all pointers 0; storage contents are not reset. While reset_i is high, outputs are forced to ready_o = 0 and v_o = 0. In the first cycle after reset: ready_o = 1, v_o = 0, empty_o = 1, free_cnt_o = els_p, pending and inflight counts 0.
- Full and ready:
  - full = (wptr - cptr == els_p); ready_o = ~full.
  - ready_o is computed from registered state only. Slots freed by deq_cnt_i become visible next cycle; there is no same-cycle bypass.
- Enqueue: v_i & ready_o writes data_i at wptr; wptr increments next cycle. Enqueuing with ready_o = 0 is illegal (assertion).
- Issue:
  - v_o = (rptr != wptr); data_o = mem[rptr] as a combinational read.
  - Latency from enqueue to v_o is 1 cycle. There is no enqueue-to-output bypass.
  - yumi_i increments rptr. yumi_i with v_o = 0 is illegal (assertion).
- Commit: cptr_n = cptr + deq_cnt_i. Requires deq_cnt_i <= rptr - cptr; violation is illegal (assertion).
- Rollback: roll_v_i sets rptr_n = cptr_n (commit is applied first). yumi_i is ignored in that cycle. wptr is unaffected; the replayed entries reappear on data_o next cycle.
- Clear: clr_v_i sets rptr_n = wptr_n = cptr_n. A same-cycle enqueue handshake completes but its data is discarded. yumi_i is ignored.
- Priority within a cycle: commit always applies; then clr over roll; then normal yumi/enqueue.
- Counters: all are combinational from registered pointers.
  - free_cnt_o = els_p - (wptr - cptr)
  - pending_cnt_o = wptr - rptr
  - inflight_cnt_o = rptr - cptr
  - empty_o = (wptr == cptr)
- Wrap-around: pointer arithmetic is modulo 2*els_p. Full and empty are distinguished by the wrap bit. No other special case is allowed.
- Simultaneous enqueue, yumi and commit in a full queue: the enqueue is blocked because ready_o = 0. yumi and commit proceed.

Decomposition:
- No new package typedefs; counts and pointers use the derived localparams.
- One sub-module: bp_be_rollback_queue_mem. It is a 1-write, 1-async-read els_p x width_p register array with write enable, write address, read address and read data.
- Pointer and counter logic stay in the top module.

Test Plan:
All scenarios use els_p = 4, deq_width_p = 2.
1. Fill and drain:
   - Enqueue A, B, C, D back-to-back → ready_o = 0 after D; free_cnt_o = 0; a further v_i is held off.
   - Yumi all 4, then deq_cnt_i = 2, 2 → empty_o = 1, free_cnt_o = 4.
2. Rollback replay:
   - Enqueue A–D; yumi A, B, C; commit 1 (A) in the same cycle as roll_v_i → next cycle data_o = B, pending_cnt_o = 3, inflight_cnt_o = 0.
3. Clear:
   - With A–C enqueued, A issued, A committed, pulse clr_v_i with a concurrent enqueue of D → next cycle v_o = 0, empty_o = 1, free_cnt_o = 4; D is never presented.
4. Wrap-around:
   - Run 10 enqueue/yumi/commit-1 cycles in steady state → data_o order preserved across pointer wrap; ready_o never deasserts; inflight_cnt_o <= 1.
5. Multi-commit while full:
   - Full queue, all issued; deq_cnt_i = 2 → ready_o = 0 in that cycle, then 1 in the next cycle with free_cnt_o = 2.
6. Reset mid-operation:
   - 3 entries held, assert reset_i for 1 cycle → v_o = 0 and ready_o = 0 during reset; next cycle ready_o = 1, free_cnt_o = 4, empty_o = 1.

Source files
------------

// File: rtl/bp_be_rollback_queue_pkg.sv
// Shared defaults for the BE rollback queue slice.
package bp_be_rollback_queue_pkg;

  localparam int unsigned els_default_lp       = 16;
  localparam int unsigned width_default_lp     = 128;
  localparam int unsigned deq_width_default_lp = 2;

endpackage

// File: rtl/bp_be_rollback_queue_if.sv
// Enqueue, issue, commit/rollback and occupancy signals between the FE queue, the BE and the queue.
interface bp_be_rollback_queue_if
  import bp_be_rollback_queue_pkg::*;
#(
  parameter int unsigned els_p       = els_default_lp,
  parameter int unsigned width_p     = width_default_lp,
  parameter int unsigned deq_width_p = deq_width_default_lp
) ();

  localparam int unsigned cnt_width_lp     = $clog2(els_p + 1);
  localparam int unsigned deq_cnt_width_lp = $clog2(deq_width_p + 1);

  logic [width_p-1:0]          data_i;
  logic                        v_i;
  logic                        ready_o;
  logic [width_p-1:0]          data_o;
  logic                        v_o;
  logic                        yumi_i;
  logic [deq_cnt_width_lp-1:0] deq_cnt_i;
  logic                        roll_v_i;
  logic                        clr_v_i;
  logic                        empty_o;
  logic [cnt_width_lp-1:0]     free_cnt_o;
  logic [cnt_width_lp-1:0]     pending_cnt_o;
  logic [cnt_width_lp-1:0]     inflight_cnt_o;

  modport master (
    output data_i, v_i, yumi_i, deq_cnt_i, roll_v_i, clr_v_i,
    input  ready_o, data_o, v_o, empty_o, free_cnt_o, pending_cnt_o, inflight_cnt_o
  );

  modport slave (
    input  data_i, v_i, yumi_i, deq_cnt_i, roll_v_i, clr_v_i,
    output ready_o, data_o, v_o, empty_o, free_cnt_o, pending_cnt_o, inflight_cnt_o
  );

endinterface

// File: rtl/bp_be_rollback_queue_mem.sv
// 1-write / 1-async-read register array backing the rollback queue; contents are not reset.
module bp_be_rollback_queue_mem #(
  parameter int unsigned els_p   = 16,
  parameter int unsigned width_p = 128
) (
  input  logic                       clk_i,
  input  logic                       w_v_i,
  input  logic [$clog2(els_p)-1:0]   w_addr_i,
  input  logic [width_p-1:0]         w_data_i,
  input  logic [$clog2(els_p)-1:0]   r_addr_i,
  output logic [width_p-1:0]         r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_rollback_queue.sv
// Replayable FE->BE instruction buffer: entries stay resident from enqueue until commit,
// so a rollback can re-issue everything uncommitted and a clear can drop it.
module bp_be_rollback_queue
  import bp_be_rollback_queue_pkg::*;
#(
  parameter int unsigned els_p       = els_default_lp,
  parameter int unsigned width_p     = width_default_lp,
  parameter int unsigned deq_width_p = deq_width_default_lp
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_be_rollback_queue_if.slave q
);

  localparam int unsigned addr_width_lp = $clog2(els_p);
  localparam int unsigned ptr_width_lp  = addr_width_lp + 1;
  localparam int unsigned cnt_width_lp  = $clog2(els_p + 1);

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic [ptr_width_lp-1:0] occ, pending, inflight;
  logic                    full, enq, issue;

  // Distances are modulo 2*els_p; the wrap bit separates full from empty.
  assign occ      = wptr_r - cptr_r;
  assign pending  = wptr_r - rptr_r;
  assign inflight = rptr_r - cptr_r;
  assign full     = (occ == ptr_width_lp'(els_p));

  assign q.ready_o = ~full & ~reset_i;
  assign q.v_o     = (rptr_r != wptr_r) & ~reset_i;
  assign enq       = q.v_i & q.ready_o;
  assign issue     = q.yumi_i & q.v_o;

  assign q.empty_o        = (wptr_r == cptr_r);
  assign q.free_cnt_o     = cnt_width_lp'(els_p) - cnt_width_lp'(occ);
  assign q.pending_cnt_o  = cnt_width_lp'(pending);
  assign q.inflight_cnt_o = cnt_width_lp'(inflight);

  // Commit always applies; clear beats rollback, which beats normal issue/enqueue.
  always_comb begin
    cptr_n = cptr_r + ptr_width_lp'(q.deq_cnt_i);
    wptr_n = wptr_r + ptr_width_lp'(enq);
    rptr_n = rptr_r + ptr_width_lp'(issue);
    if (q.clr_v_i) begin
      wptr_n = cptr_n;
      rptr_n = cptr_n;
    end else if (q.roll_v_i) begin
      rptr_n = cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  bp_be_rollback_queue_mem #(
    .els_p   (els_p),
    .width_p (width_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq & ~q.clr_v_i),
    .w_addr_i (wptr_r[addr_width_lp-1:0]),
    .w_data_i (q.data_i),
    .r_addr_i (rptr_r[addr_width_lp-1:0]),
    .r_data_o (q.data_o)
  );

  // Protocol checks on the producer, issue and commit sides.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(q.v_i && !q.ready_o))
        else $error("bp_be_rollback_queue: enqueue while not ready");
      assert (!(q.yumi_i && !q.v_o))
        else $error("bp_be_rollback_queue: yumi without valid entry");
      assert ((ptr_width_lp'(q.deq_cnt_i) <= inflight) && (32'(q.deq_cnt_i) <= deq_width_p))
        else $error("bp_be_rollback_queue: commit exceeds issued entries");
    end
  end

endmodule

// File: tb/tb_bp_be_rollback_queue.sv
// Directed bench for bp_be_rollback_queue with els_p=4, deq_width_p=2.
module tb_bp_be_rollback_queue;

  localparam int unsigned els_lp   = 4;
  localparam int unsigned width_lp = 16;
  localparam int unsigned deq_lp   = 2;

  logic clk;
  logic reset_i;
  int   errors;
  int   checks;

  bp_be_rollback_queue_if #(.els_p(els_lp), .width_p(width_lp), .deq_width_p(deq_lp)) q ();

  bp_be_rollback_queue #(
    .els_p       (els_lp),
    .width_p     (width_lp),
    .deq_width_p (deq_lp)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q.v_i       = 1'b0;
    q.data_i    = '0;
    q.yumi_i    = 1'b0;
    q.deq_cnt_i = 2'd0;
    q.roll_v_i  = 1'b0;
    q.clr_v_i   = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_i = 1'b1;
    idle();
    #1;
    chk("rst_ready_low", 32'(q.ready_o), 32'd0);
    chk("rst_v_low", 32'(q.v_o), 32'd0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("post_rst_ready", 32'(q.ready_o), 32'd1);
    chk("post_rst_v", 32'(q.v_o), 32'd0);
    chk("post_rst_empty", 32'(q.empty_o), 32'd1);
    chk("post_rst_free", 32'(q.free_cnt_o), 32'd4);
    chk("post_rst_pending", 32'(q.pending_cnt_o), 32'd0);
    chk("post_rst_inflight", 32'(q.inflight_cnt_o), 32'd0);

    // 1: fill and drain
    q.v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.data_i = 16'(32'hA000 + i);
      tick();
    end
    q.v_i = 1'b0;
    chk("s1_ready_full", 32'(q.ready_o), 32'd0);
    chk("s1_free_full", 32'(q.free_cnt_o), 32'd0);
    chk("s1_pending_full", 32'(q.pending_cnt_o), 32'd4);
    q.yumi_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("s1_issue_data", 32'(q.data_o), 32'hA000 + 32'(i));
      tick();
    end
    q.yumi_i = 1'b0;
    chk("s1_v_drained", 32'(q.v_o), 32'd0);
    chk("s1_inflight4", 32'(q.inflight_cnt_o), 32'd4);
    chk("s1_still_full", 32'(q.ready_o), 32'd0);
    q.deq_cnt_i = 2'd2;
    tick();
    chk("s1_free_after_c2", 32'(q.free_cnt_o), 32'd2);
    chk("s1_inflight_after_c2", 32'(q.inflight_cnt_o), 32'd2);
    tick();
    q.deq_cnt_i = 2'd0;
    chk("s1_empty", 32'(q.empty_o), 32'd1);
    chk("s1_free4", 32'(q.free_cnt_o), 32'd4);

    // 2: rollback replay
    q.v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.data_i = 16'(32'h2000 + i);
      tick();
    end
    q.v_i = 1'b0;
    q.yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("s2_issue_data", 32'(q.data_o), 32'h2000 + 32'(i));
      tick();
    end
    q.yumi_i    = 1'b0;
    q.deq_cnt_i = 2'd1;
    q.roll_v_i  = 1'b1;
    tick();
    idle();
    chk("s2_replay_v", 32'(q.v_o), 32'd1);
    chk("s2_replay_data", 32'(q.data_o), 32'h2001);
    chk("s2_pending3", 32'(q.pending_cnt_o), 32'd3);
    chk("s2_inflight0", 32'(q.inflight_cnt_o), 32'd0);
    chk("s2_free1", 32'(q.free_cnt_o), 32'd1);
    q.yumi_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("s2_replay_seq", 32'(q.data_o), 32'h2000 + 32'(i));
      tick();
    end
    q.yumi_i    = 1'b0;
    q.deq_cnt_i = 2'd2;
    tick();
    q.deq_cnt_i = 2'd1;
    tick();
    idle();
    chk("s2_empty", 32'(q.empty_o), 32'd1);

    // 3: clear with concurrent enqueue
    q.v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q.data_i = 16'(32'h3000 + i);
      tick();
    end
    q.v_i = 1'b0;
    chk("s3_issue_a", 32'(q.data_o), 32'h3000);
    q.yumi_i = 1'b1;
    tick();
    q.yumi_i    = 1'b0;
    q.deq_cnt_i = 2'd1;
    tick();
    q.deq_cnt_i = 2'd0;
    chk("s3_pre_clr_data", 32'(q.data_o), 32'h3001);
    q.clr_v_i = 1'b1;
    q.v_i     = 1'b1;
    q.data_i  = 16'h3003;
    tick();
    idle();
    chk("s3_v_cleared", 32'(q.v_o), 32'd0);
    chk("s3_empty", 32'(q.empty_o), 32'd1);
    chk("s3_free4", 32'(q.free_cnt_o), 32'd4);
    chk("s3_pending0", 32'(q.pending_cnt_o), 32'd0);
    tick();
    chk("s3_d_never_shown", 32'(q.v_o), 32'd0);

    // 4: steady-state streaming across pointer wrap
    for (int k = 0; k < 10; k++) begin
      q.v_i       = 1'b1;
      q.data_i    = 16'(32'h4000 + k);
      q.yumi_i    = (k >= 1);
      q.deq_cnt_i = (k >= 2) ? 2'd1 : 2'd0;
      chk("s4_ready", 32'(q.ready_o), 32'd1);
      chk("s4_inflight", 32'(q.inflight_cnt_o), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 1) chk("s4_order", 32'(q.data_o), 32'h4000 + 32'(k - 1));
      tick();
    end
    q.v_i       = 1'b0;
    q.yumi_i    = 1'b1;
    q.deq_cnt_i = 2'd1;
    chk("s4_last_data", 32'(q.data_o), 32'h4009);
    tick();
    q.yumi_i = 1'b0;
    chk("s4_last_inflight", 32'(q.inflight_cnt_o), 32'd1);
    tick();
    idle();
    chk("s4_empty", 32'(q.empty_o), 32'd1);

    // 5: multi-commit while full
    q.v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.data_i = 16'(32'h5000 + i);
      tick();
    end
    q.v_i    = 1'b0;
    q.yumi_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("s5_issue_data", 32'(q.data_o), 32'h5000 + 32'(i));
      tick();
    end
    q.yumi_i    = 1'b0;
    q.deq_cnt_i = 2'd2;
    #1;
    chk("s5_ready_same_cycle", 32'(q.ready_o), 32'd0);
    tick();
    chk("s5_ready_next", 32'(q.ready_o), 32'd1);
    chk("s5_free2", 32'(q.free_cnt_o), 32'd2);
    tick();
    idle();
    chk("s5_empty", 32'(q.empty_o), 32'd1);

    // 6: reset mid-operation
    q.v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q.data_i = 16'(32'h6000 + i);
      tick();
    end
    q.v_i = 1'b0;
    chk("s6_held_v", 32'(q.v_o), 32'd1);
    chk("s6_held_pending", 32'(q.pending_cnt_o), 32'd3);
    reset_i = 1'b1;
    #1;
    chk("s6_rst_v", 32'(q.v_o), 32'd0);
    chk("s6_rst_ready", 32'(q.ready_o), 32'd0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("s6_ready", 32'(q.ready_o), 32'd1);
    chk("s6_free4", 32'(q.free_cnt_o), 32'd4);
    chk("s6_empty", 32'(q.empty_o), 32'd1);
    chk("s6_v", 32'(q.v_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
